instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 32: instruction word width.
REQ-002 SHALL have parameter INSTR_MEM_ADDR_WIDTH, default 10: instruction memory address / PC width.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins fetching at start_pc.
REQ-006 SHALL have port start_pc  input  INSTR_MEM_ADDR_WIDTH  first fetch address.
REQ-007 SHALL have port mem_addr  output  INSTR_MEM_ADDR_WIDTH  read address to the instruction memory.
REQ-008 SHALL have port mem_instr  input  INSTR_WIDTH  memory read data, valid exactly 1 cycle after mem_addr is presented.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump request.
REQ-010 SHALL have port redirect_pc  input  INSTR_MEM_ADDR_WIDTH  redirect target.
REQ-011 SHALL have port instr_valid  output  1  instr_data/instr_pc hold a fetched word.
REQ-012 SHALL have port instr_ready  input  1  downstream accepts; transfer when instr_valid && instr_ready.
REQ-013 SHALL have port instr_data  output  INSTR_WIDTH  fetched instruction.
REQ-014 SHALL have port instr_pc  output  INSTR_MEM_ADDR_WIDTH  address of instr_data.
REQ-015 SHALL have ports busy, halted, error  output  1 each  status flags.

Function
REQ-016 SHALL implement states IDLE, FETCH, DRAIN, HALTED, ERROR.
REQ-017 IDLE/HALTED/ERROR + start SHALL clear buffer and flags, load PC=start_pc, enter FETCH; start in FETCH or DRAIN SHALL be ignored.
REQ-018 In FETCH, a fetch SHALL be issued (mem_addr=PC, PC<=PC+1) only when buffered words + in-flight fetches < 2; at most one fetch per cycle.
REQ-019 PC increment SHALL wrap modulo 2^INSTR_MEM_ADDR_WIDTH (1023 -> 0 at default).
REQ-020 Each returned word SHALL be tagged with its issue address and enqueued in a 2-entry in-order buffer; instr_* SHALL present the buffer head.
REQ-021 With instr_ready held high and no halt/redirect, throughput SHALL be one instruction per cycle; first instr_valid 2 cycles after the start cycle.
REQ-022 instr_valid SHALL stay high and instr_data/instr_pc stable until accepted.
REQ-023 Returned word with opcode [31:24] == HALT_OPCODE (8'h01) SHALL be enqueued, issue SHALL stop, any younger in-flight word SHALL be discarded, state -> DRAIN.
REQ-024 Returned word == INVALID_INSTR (all ones) SHALL NOT be enqueued; younger in-flight discarded; state -> DRAIN with error pending.
REQ-025 DRAIN SHALL exit to HALTED (or ERROR if error pending) the cycle after the buffer empties.
REQ-026 redirect_valid in FETCH or DRAIN SHALL, in that cycle, flush buffer and in-flight word, deassert instr_valid next cycle, clear pending halt/error, set PC=redirect_pc, state -> FETCH; first redirected fetch issued the following cycle.
REQ-027 redirect_valid in IDLE/HALTED/ERROR SHALL be ignored; redirect and start never coincide (start wins if they do).
REQ-028 A transfer coinciding with a redirect SHALL count as accepted; the flush applies to everything else.
REQ-029 busy SHALL be 1 in FETCH and DRAIN; halted=1 only in HALTED; error=1 only in ERROR.
REQ-030 mem_addr SHALL hold its last value when no fetch is issued.

Reset
REQ-031 rst SHALL force IDLE, PC=0, mem_addr=0, empty buffer, no in-flight fetch, instr_valid=0, instr_data=0, instr_pc=0, busy=0, halted=0, error=0.
REQ-032 rst mid-operation SHALL discard all buffered and in-flight words; the data-return cycle after rst SHALL be ignored.

Structure
REQ-033 HALT_OPCODE, INVALID_INSTR, opcode field bounds and the state enum SHALL live in shared package tsp_pkg.
REQ-034 The 2-entry buffer SHALL be sub-module fetch_skid_buffer (valid/ready in and out, synchronous flush).

Verification
REQ-035 Memory words 0..3 = NOP, start_pc=0, ready=1 -> instr_pc 0,1,2,3 on consecutive cycles, first valid 2 cycles after start.
REQ-036 ready=0 for 5 cycles mid-stream -> instr_valid held, instr_pc stable, no duplicates or gaps, ≤2 words buffered.
REQ-037 start_pc=1022, sequential NOPs -> instr_pc 1022, 1023, 0, 1.
REQ-038 Word at addr 3 = 32'h01000000 -> words 0..3 delivered, word 4 never delivered, halted=1, busy=0.
REQ-039 Word at addr 2 = 32'hFFFFFFFF -> words 0,1 delivered only, error=1; then start -> error=0, fetch restarts.
REQ-040 redirect_pc=100 during backpressure with 2 buffered -> buffered words dropped, next delivered instr_pc=100; rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/tsp_pkg.sv
// Shared constants and state encoding for the instruction fetch slice.
package tsp_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 24;

  localparam logic [7:0]  HALT_OPCODE   = 8'h01;
  localparam logic [31:0] INVALID_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_HALTED,
    ST_ERROR
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry in-order buffer; an arriving word falls straight through to the
// output when the buffer is empty and the consumer is ready.
module fetch_skid_buffer #(
  parameter int WIDTH = 42
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd;
  logic             r_wr;
  logic [1:0]       r_count;

  logic w_empty;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_empty     = (r_count == 2'd0);
  assign o_in_ready  = (r_count != 2'd2);
  assign o_out_valid = !w_empty || i_in_valid;
  assign o_count     = r_count;

  // Output data is zero whenever nothing is being presented.
  always_comb begin
    o_out_data = '0;
    if (!w_empty)
      o_out_data = r_mem[r_rd];
    else if (i_in_valid)
      o_out_data = i_in_data;
  end

  assign w_bypass = w_empty && i_in_valid && i_out_ready;
  assign w_push   = i_in_valid && o_in_ready && !w_bypass;
  assign w_pop    = !w_empty && i_out_ready;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push)
        r_wr <= ~r_wr;
      if (w_pop)
        r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= i_in_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: issues sequential reads to a 1-cycle-latency
// instruction memory and hands tagged words downstream through a 2-entry buffer.
module instruction_fetch #(
  parameter int INSTR_WIDTH          = 32,
  parameter int INSTR_MEM_ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] start_pc,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [INSTR_WIDTH-1:0]          mem_instr,
  input  logic                            redirect_valid,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] redirect_pc,
  output logic                            instr_valid,
  input  logic                            instr_ready,
  output logic [INSTR_WIDTH-1:0]          instr_data,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_pc,
  output logic                            busy,
  output logic                            halted,
  output logic                            error
);

  import tsp_pkg::*;

  localparam int AW      = INSTR_MEM_ADDR_WIDTH;
  localparam int ENTRY_W = INSTR_WIDTH + AW;

  fetch_state_e r_state;
  fetch_state_e w_next_state;

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_mem_addr;
  logic [AW-1:0] r_inflight_pc;
  logic          r_inflight;
  logic          r_err_pending;

  logic               w_start;
  logic               w_redirect;
  logic               w_flush;
  logic               w_issue;
  logic               w_ret_valid;
  logic               w_ret_halt;
  logic               w_ret_invalid;
  logic [1:0]         w_buf_count;
  logic [1:0]         w_occupancy;
  logic               w_buf_in_ready;
  logic               w_buf_in_valid;
  logic [ENTRY_W-1:0] w_buf_out_data;

  assign w_start    = start && (r_state == ST_IDLE || r_state == ST_HALTED ||
                                r_state == ST_ERROR);
  assign w_redirect = redirect_valid && (r_state == ST_FETCH || r_state == ST_DRAIN);
  assign w_flush    = w_start || w_redirect;

  // Only one read can be outstanding because memory latency is one cycle.
  assign w_occupancy = w_buf_count + {1'b0, r_inflight};
  assign w_issue     = (r_state == ST_FETCH) && !w_redirect && (w_occupancy < 2'd2);
  assign mem_addr    = w_issue ? r_pc : r_mem_addr;

  // Returns arriving outside FETCH belong to a discarded younger fetch.
  assign w_ret_valid    = r_inflight && (r_state == ST_FETCH);
  assign w_ret_halt     = (mem_instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
  assign w_ret_invalid  = (mem_instr == INVALID_INSTR);
  assign w_buf_in_valid = w_ret_valid && !w_ret_invalid && w_buf_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_mem_addr    <= '0;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_err_pending <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_pc          <= start_pc;
        r_inflight    <= 1'b0;
        r_err_pending <= 1'b0;
      end else if (w_redirect) begin
        r_pc          <= redirect_pc;
        r_inflight    <= 1'b0;
        r_err_pending <= 1'b0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_pc          <= r_pc + AW'(1);
          r_mem_addr    <= r_pc;
          r_inflight_pc <= r_pc;
        end
        if (w_ret_valid && w_ret_invalid)
          r_err_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_HALTED, ST_ERROR: begin
        if (start)
          w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_valid)
          w_next_state = ST_FETCH;
        else if (w_ret_valid && (w_ret_halt || w_ret_invalid))
          w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (redirect_valid)
          w_next_state = ST_FETCH;
        else if (w_buf_count == 2'd0)
          w_next_state = r_err_pending ? ST_ERROR : ST_HALTED;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  fetch_skid_buffer #(
    .WIDTH (ENTRY_W)
  ) u_buffer (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (w_flush),
    .i_in_valid  (w_buf_in_valid),
    .o_in_ready  (w_buf_in_ready),
    .i_in_data   ({r_inflight_pc, mem_instr}),
    .o_out_valid (instr_valid),
    .i_out_ready (instr_ready),
    .o_out_data  (w_buf_out_data),
    .o_count     (w_buf_count)
  );

  assign instr_pc   = w_buf_out_data[ENTRY_W-1:INSTR_WIDTH];
  assign instr_data = w_buf_out_data[INSTR_WIDTH-1:0];

  assign busy   = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign halted = (r_state == ST_HALTED);
  assign error  = (r_state == ST_ERROR);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 1-cycle-latency memory model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  start_pc;
  logic [9:0]  mem_addr;
  logic [31:0] mem_instr;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [9:0]  instr_pc;
  logic        busy;
  logic        halted;
  logic        error;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_instr <= mem[mem_addr];

  instruction_fetch #(
    .INSTR_WIDTH          (32),
    .INSTR_MEM_ADDR_WIDTH (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_pc       (start_pc),
    .mem_addr       (mem_addr),
    .mem_instr      (mem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .busy           (busy),
    .halted         (halted),
    .error          (error)
  );

  function automatic logic [31:0] nopWord(input int a);
    return 32'h1300_0000 | 32'(a);
  endfunction

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic applyStimulus(input logic r, input logic s, input logic [9:0] spc,
                               input logic rv, input logic [9:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst            = r;
    start          = s;
    start_pc       = spc;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " valid"},  32'(instr_valid), 32'd0);
    checkOutput({tag, " data"},   instr_data,       32'd0);
    checkOutput({tag, " pc"},     32'(instr_pc),    32'd0);
    checkOutput({tag, " addr"},   32'(mem_addr),    32'd0);
    checkOutput({tag, " busy"},   32'(busy),        32'd0);
    checkOutput({tag, " halted"}, 32'(halted),      32'd0);
    checkOutput({tag, " error"},  32'(error),       32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = nopWord(i);
    rst = 1'b1; start = 1'b0; start_pc = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

    applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkIdleOutputs("reset");

    // Sequential stream from address 0
    applyStimulus(1'b0, 1'b1, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("start busy", 32'(busy), 32'd0);
    checkOutput("start addr", 32'(mem_addr), 32'd0);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("s1 busy", 32'(busy), 32'd1);
    checkOutput("s1 valid", 32'(instr_valid), 32'd0);
    checkOutput("s1 addr", 32'(mem_addr), 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
      checkOutput("seq valid", 32'(instr_valid), 32'd1);
      checkOutput("seq pc", 32'(instr_pc), 32'(k));
      checkOutput("seq data", instr_data, nopWord(k));
      checkOutput("seq addr", 32'(mem_addr), 32'(k + 1));
    end

    // Backpressure: word 4 held, word 5 buffered behind it, no further fetch
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b0);
      checkOutput("hold valid", 32'(instr_valid), 32'd1);
      checkOutput("hold pc", 32'(instr_pc), 32'd4);
      checkOutput("hold data", instr_data, nopWord(4));
      checkOutput("hold addr", 32'(mem_addr), 32'd5);
    end
    for (int k = 4; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
      checkOutput("resume valid", 32'(instr_valid), 32'd1);
      checkOutput("resume pc", 32'(instr_pc), 32'(k));
    end

    // Reset mid-stream
    applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkIdleOutputs("midreset");
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("post-reset valid", 32'(instr_valid), 32'd0);

    // Halt opcode at address 3
    mem[3] = 32'h0100_0000;
    applyStimulus(1'b0, 1'b1, 10'd0, 1'b0, 10'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
      checkOutput("halt seq pc", 32'(instr_pc), 32'(k));
      checkOutput("halt seq data", instr_data, (k == 3) ? 32'h0100_0000 : nopWord(k));
    end
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("drain valid", 32'(instr_valid), 32'd0);
    checkOutput("drain busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("halted flag", 32'(halted), 32'd1);
    checkOutput("halted busy", 32'(busy), 32'd0);
    checkOutput("halted valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("no word4", 32'(instr_valid), 32'd0);

    // Invalid word at address 2
    mem[3] = nopWord(3);
    mem[2] = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 1'b1, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("restart halted", 32'(halted), 32'd1);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("restart halted clr", 32'(halted), 32'd0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
      checkOutput("err seq valid", 32'(instr_valid), 32'd1);
      checkOutput("err seq pc", 32'(instr_pc), 32'(k));
    end
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("invalid dropped", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("err drain valid", 32'(instr_valid), 32'd0);
    checkOutput("err drain flag", 32'(error), 32'd0);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("error flag", 32'(error), 32'd1);
    checkOutput("error busy", 32'(busy), 32'd0);

    // Restart from ERROR, then redirect under backpressure
    mem[2] = nopWord(2);
    applyStimulus(1'b0, 1'b1, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("restart error", 32'(error), 32'd1);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("restart error clr", 32'(error), 32'd0);
    checkOutput("restart busy", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
      checkOutput("restart pc", 32'(instr_pc), 32'(k));
      checkOutput("restart data", instr_data, nopWord(k));
    end
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b0);
    checkOutput("bp1 pc", 32'(instr_pc), 32'd3);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b0);
    checkOutput("bp2 pc", 32'(instr_pc), 32'd3);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b1, 10'd100, 1'b0);
    checkOutput("redir cycle pc", 32'(instr_pc), 32'd3);
    checkOutput("redir cycle addr", 32'(mem_addr), 32'd4);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b0);
    checkOutput("redir flush valid", 32'(instr_valid), 32'd0);
    checkOutput("redir fetch addr", 32'(mem_addr), 32'd100);
    checkOutput("redir busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b0);
    checkOutput("redir valid", 32'(instr_valid), 32'd1);
    checkOutput("redir pc", 32'(instr_pc), 32'd100);
    checkOutput("redir data", instr_data, nopWord(100));
    for (int k = 100; k < 103; k++) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
      checkOutput("redir stream valid", 32'(instr_valid), 32'd1);
      checkOutput("redir stream pc", 32'(instr_pc), 32'(k));
    end

    // PC wrap-around from 1022
    applyStimulus(1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 10'd1022, 1'b0, 10'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
    checkOutput("wrap first addr", 32'(mem_addr), 32'd1022);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b1);
      checkOutput("wrap valid", 32'(instr_valid), 32'd1);
      checkOutput("wrap pc", 32'(instr_pc), 32'((1022 + k) % 1024));
      checkOutput("wrap data", instr_data, nopWord((1022 + k) % 1024));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
